// File: rtl/bram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : bram_pkg                                                |
// | Purpose  : Shared defaults and encodings for the BRAM arbiter.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package bram_pkg;

  // A 1024x768 frame (786,432 words) fits in the default address space.
  localparam int RAM_WIDTH_DEF     = 24;
  localparam int RAM_ADDR_BITS_DEF = 20;
  localparam int MAX_BURST_DEF     = 16;

  // Arbiter ownership: IDLE means no locked burst is in progress.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  // Identity of a requester, used for round-robin history.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_bram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bram_arbiter_bram                                       |
// | Purpose  : Single-port read-first block RAM with registered output.|
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module bram_arbiter_bram
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ram_enable,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     input_data,
  output logic [RAM_WIDTH-1:0]     output_data
);

  localparam int DEPTH = 1 << RAM_ADDR_BITS;

  logic [RAM_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [RAM_WIDTH-1:0] output_data_q;

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_enable && write_enable) begin
      mem_q[address] <= input_data;
    end
  end

  // Output register samples the pre-write word (read-first behaviour).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      output_data_q <= '0;
    end else if (ram_enable) begin
      output_data_q <= mem_q[address];
    end
  end

  assign output_data = output_data_q;

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bram_arbiter                                            |
// | Purpose  : Two-requester round-robin arbiter with burst lock in    |
// |            front of a single-port block RAM.                       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int MAX_BURST     = MAX_BURST_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     a_valid,
  input  logic                     a_write,
  input  logic                     a_lock,
  input  logic [RAM_ADDR_BITS-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0]     a_wdata,
  input  logic                     b_valid,
  input  logic                     b_write,
  input  logic                     b_lock,
  input  logic [RAM_ADDR_BITS-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0]     b_wdata,
  output logic                     a_ready,
  output logic                     b_ready,
  output logic                     a_rvalid,
  output logic                     b_rvalid,
  output logic [RAM_WIDTH-1:0]     rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  req_id_e          last_grant_q, last_grant_d;
  logic             a_rvalid_q, b_rvalid_q;

  logic grant_a, grant_b;
  logic exhausted;
  logic same_owner;
  logic xfer;
  logic xfer_lock;
  logic xfer_write;

  logic                     ram_enable;
  logic                     ram_write;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]     ram_wdata;

  // Grant selection: lone requester wins, else burst owner, else round-robin.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    exhausted = (beat_cnt_q == CNT_W'(MAX_BURST));
    if (reset_n) begin
      if (a_valid && !b_valid) begin
        grant_a = 1'b1;
      end else if (b_valid && !a_valid) begin
        grant_b = 1'b1;
      end else if (a_valid && b_valid) begin
        unique case (state_q)
          ST_OWN_A: begin
            if (exhausted) grant_b = 1'b1;
            else           grant_a = 1'b1;
          end
          ST_OWN_B: begin
            if (exhausted) grant_a = 1'b1;
            else           grant_b = 1'b1;
          end
          default: begin
            if (last_grant_q == REQ_B) grant_a = 1'b1;
            else                       grant_b = 1'b1;
          end
        endcase
      end
    end
  end

  assign xfer       = grant_a | grant_b;
  assign xfer_lock  = grant_a ? a_lock  : b_lock;
  assign xfer_write = grant_a ? a_write : b_write;
  assign same_owner = (state_q == ST_OWN_A && grant_a) || (state_q == ST_OWN_B && grant_b);

  // Next ownership: a locked beat keeps/takes ownership unless the owner's
  // burst is already at its limit, in which case the burst ends here.
  always_comb begin
    state_d      = ST_IDLE;
    beat_cnt_d   = '0;
    last_grant_d = last_grant_q;
    if (xfer) begin
      if (grant_a) last_grant_d = REQ_A;
      else         last_grant_d = REQ_B;
      if (xfer_lock && !(exhausted && same_owner)) begin
        state_d    = grant_a ? ST_OWN_A : ST_OWN_B;
        beat_cnt_d = same_owner ? (beat_cnt_q + CNT_W'(1)) : CNT_W'(1);
      end
    end
  end

  // Arbiter state and read-response tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      last_grant_q <= REQ_B;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
      a_rvalid_q   <= grant_a && !a_write;
      b_rvalid_q   <= grant_b && !b_write;
    end
  end

  assign ram_enable = xfer;
  assign ram_write  = xfer_write;
  assign ram_addr   = grant_b ? b_addr  : a_addr;
  assign ram_wdata  = grant_b ? b_wdata : a_wdata;

  bram_arbiter_bram #(
    .RAM_WIDTH     (RAM_WIDTH),
    .RAM_ADDR_BITS (RAM_ADDR_BITS)
  ) u_bram (
    .clock        (clock),
    .reset_n      (reset_n),
    .ram_enable   (ram_enable),
    .write_enable (ram_write),
    .address      (ram_addr),
    .input_data   (ram_wdata),
    .output_data  (rdata)
  );

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_bram_arbiter                                         |
// | Purpose  : Self-checking bench for bram_arbiter.                   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_bram_arbiter;

  localparam int W  = 24;
  localparam int AB = 20;
  localparam int MB = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_valid, a_write, a_lock, b_valid, b_write, b_lock;
  logic [AB-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic          a_ready, b_ready, a_rvalid, b_rvalid;
  logic [W-1:0]  rdata;

  int total = 0;
  int bad   = 0;

  bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_write(a_write), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_write(b_write), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ready(a_ready), .b_ready(b_ready), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic v, input logic w, input logic l,
                       input logic [AB-1:0] ad, input logic [W-1:0] d);
    a_valid = v; a_write = w; a_lock = l; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic w, input logic l,
                       input logic [AB-1:0] ad, input logic [W-1:0] d);
    b_valid = v; b_write = w; b_lock = l; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle_inputs();
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic preload(input logic [AB-1:0] ad, input logic [W-1:0] d);
    set_a(1'b1, 1'b1, 1'b0, ad, d);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Reset outputs, then both requesters contend on the first edge after release.
  task automatic test_reset();
    reset_n = 1'b0;
    set_a(1'b1, 1'b0, 1'b0, 20'h00010, '0);
    set_b(1'b1, 1'b0, 1'b0, 20'h00020, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_flags cycle %0d: got %b want 0000", i, {a_ready, b_ready, a_rvalid, b_rvalid});
      end
      total++;
      if (rdata !== '0) begin
        bad++;
        $display("FAIL reset_rdata cycle %0d: got %h want 000000", i, rdata);
      end
      tick();
    end
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if ({a_ready, b_ready} !== 2'b10) begin
      bad++;
      $display("FAIL contend_first_grant: got %b want 10", {a_ready, b_ready});
    end
    tick();
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0110) begin
      bad++;
      $display("FAIL contend_second_cycle: got %b want 0110", {a_ready, b_ready, a_rvalid, b_rvalid});
    end
    total++;
    if (rdata !== 24'h5A0010) begin
      bad++;
      $display("FAIL contend_a_rdata: got %h want 5a0010", rdata);
    end
    tick();
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({a_rvalid, b_rvalid} !== 2'b01) begin
      bad++;
      $display("FAIL contend_b_rvalid: got %b want 01", {a_rvalid, b_rvalid});
    end
    total++;
    if (rdata !== 24'hA50020) begin
      bad++;
      $display("FAIL contend_b_rdata: got %h want a50020", rdata);
    end
    tick();
  endtask

  // A writes, B reads the same word on the very next cycle.
  task automatic test_write_read();
    set_a(1'b1, 1'b1, 1'b0, 20'h0BFFFF, 24'hABCDEF);
    @(negedge clock);
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_a_ready: got %b want 1", a_ready);
    end
    tick();
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b0, 1'b0, 20'h0BFFFF, '0);
    @(negedge clock);
    total++;
    if ({b_ready, a_rvalid, b_rvalid} !== 3'b100) begin
      bad++;
      $display("FAIL wr_b_ready_no_rvalid: got %b want 100", {b_ready, a_rvalid, b_rvalid});
    end
    tick();
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if ({a_rvalid, b_rvalid} !== 2'b01) begin
      bad++;
      $display("FAIL wr_b_rvalid: got %b want 01", {a_rvalid, b_rvalid});
    end
    total++;
    if (rdata !== 24'hABCDEF) begin
      bad++;
      $display("FAIL wr_b_rdata: got %h want abcdef", rdata);
    end
    tick();
  endtask

  // Overwrite of a known word: no response for the write, new data on a later read.
  task automatic test_read_first();
    preload(20'h00005, 24'h000001);
    set_a(1'b1, 1'b1, 1'b0, 20'h00005, 24'h123456);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 20'h00005, '0);
    @(negedge clock);
    total++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL rf_write_no_rvalid: got %b want 00", {a_rvalid, b_rvalid});
    end
    tick();
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    total++;
    if (a_rvalid !== 1'b1 || rdata !== 24'h123456) begin
      bad++;
      $display("FAIL rf_read_new: got rvalid=%b rdata=%h want 1 123456", a_rvalid, rdata);
    end
    tick();
  endtask

  // Reset lands between acceptance and response; memory must survive.
  task automatic test_reset_mid_read();
    set_a(1'b1, 1'b0, 1'b0, 20'h00010, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    reset_n = 1'b0;
    @(negedge clock);
    total++;
    if ({a_ready, a_rvalid, b_rvalid} !== 3'b000 || rdata !== '0) begin
      bad++;
      $display("FAIL mid_read_dropped: got flags=%b rdata=%h want 000 000000", {a_ready, a_rvalid, b_rvalid}, rdata);
    end
    tick();
    tick();
    reset_n = 1'b1;
    set_a(1'b1, 1'b0, 1'b0, 20'h00010, '0);
    set_b(1'b1, 1'b0, 1'b0, 20'h00020, '0);
    @(negedge clock);
    total++;
    if ({a_ready, b_ready} !== 2'b10) begin
      bad++;
      $display("FAIL mid_read_state_idle: got %b want 10", {a_ready, b_ready});
    end
    tick();
    idle_inputs();
    @(negedge clock);
    total++;
    if (a_rvalid !== 1'b1 || rdata !== 24'h5A0010) begin
      bad++;
      $display("FAIL mid_read_mem_kept: got rvalid=%b rdata=%h want 1 5a0010", a_rvalid, rdata);
    end
    tick();
  endtask

  // A holds lock continuously; B must get one beat after every MB beats of A.
  task automatic test_lock_limit();
    logic prev_b;
    logic exp_b;
    prev_b = 1'b0;
    do_reset();
    set_a(1'b1, 1'b0, 1'b1, 20'h00010, '0);
    set_b(1'b1, 1'b0, 1'b0, 20'h00020, '0);
    for (int i = 0; i < 2 * (MB + 1); i++) begin
      exp_b = ((i % (MB + 1)) == MB);
      @(negedge clock);
      total++;
      if ({a_ready, b_ready} !== {~exp_b, exp_b}) begin
        bad++;
        $display("FAIL lock_grant beat %0d: got %b want %b", i, {a_ready, b_ready}, {~exp_b, exp_b});
      end
      if (i > 0) begin
        total++;
        if ({a_rvalid, b_rvalid} !== {~prev_b, prev_b} ||
            rdata !== (prev_b ? 24'hA50020 : 24'h5A0010)) begin
          bad++;
          $display("FAIL lock_response beat %0d: got %b/%h want %b/%h", i, {a_rvalid, b_rvalid}, rdata,
                   {~prev_b, prev_b}, (prev_b ? 24'hA50020 : 24'h5A0010));
        end
      end
      prev_b = exp_b;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Nothing requested: nothing granted, nothing returned.
  task automatic test_idle();
    idle_inputs();
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0000) begin
        bad++;
        $display("FAIL idle cycle %0d: got %b want 0000", i, {a_ready, b_ready, a_rvalid, b_rvalid});
      end
      tick();
    end
  endtask

  // Random traffic against a rule-level model of arbitration and memory.
  task automatic test_random();
    logic [AB-1:0] pool [8];
    logic [W-1:0]  mem_m [logic [AB-1:0]];
    int            holder, beats, last, win, ai, bi;
    logic          av, aw, al, bv, bw, bl, exp_arv, exp_brv, w_wr, w_lk;
    logic [W-1:0]  ad, bd, exp_rd, w_d;
    logic [AB-1:0] w_ad;
    for (int k = 0; k < 8; k++) begin
      pool[k] = AB'(20'h40000 + k * 20'h111);
      mem_m[pool[k]] = W'($urandom);
      preload(pool[k], mem_m[pool[k]]);
    end
    do_reset();
    holder = -1; beats = 0; last = 1;
    exp_arv = 1'b0; exp_brv = 1'b0; exp_rd = '0;
    for (int c = 0; c < 300; c++) begin
      av = ($urandom_range(0, 9) < 7); aw = ($urandom_range(0, 9) < 3); al = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 9) < 7); bw = ($urandom_range(0, 9) < 3); bl = ($urandom_range(0, 3) != 0);
      ai = $urandom_range(0, 7); bi = $urandom_range(0, 7);
      ad = W'($urandom); bd = W'($urandom);
      set_a(av, aw, al, pool[ai], ad);
      set_b(bv, bw, bl, pool[bi], bd);
      @(negedge clock);
      win = -1;
      if (av && !bv)      win = 0;
      else if (bv && !av) win = 1;
      else if (av && bv) begin
        if (holder >= 0 && beats < MB) win = holder;
        else if (holder >= 0)          win = 1 - holder;
        else                           win = 1 - last;
      end
      total++;
      if ({a_ready, b_ready} !== {(win == 0), (win == 1)}) begin
        bad++;
        $display("FAIL rand_grant cycle %0d: got %b want %b", c, {a_ready, b_ready}, {(win == 0), (win == 1)});
      end
      total++;
      if ({a_rvalid, b_rvalid} !== {exp_arv, exp_brv}) begin
        bad++;
        $display("FAIL rand_rvalid cycle %0d: got %b want %b", c, {a_rvalid, b_rvalid}, {exp_arv, exp_brv});
      end
      if (exp_arv || exp_brv) begin
        total++;
        if (rdata !== exp_rd) begin
          bad++;
          $display("FAIL rand_rdata cycle %0d: got %h want %h", c, rdata, exp_rd);
        end
      end
      exp_arv = 1'b0; exp_brv = 1'b0;
      if (win >= 0) begin
        w_wr = (win == 0) ? aw : bw;
        w_lk = (win == 0) ? al : bl;
        w_ad = (win == 0) ? pool[ai] : pool[bi];
        w_d  = (win == 0) ? ad : bd;
        if (w_wr) begin
          mem_m[w_ad] = w_d;
        end else begin
          exp_rd = mem_m[w_ad];
          if (win == 0) exp_arv = 1'b1;
          else          exp_brv = 1'b1;
        end
        if (w_lk && !(holder == win && beats == MB)) begin
          beats  = (holder == win) ? beats + 1 : 1;
          holder = win;
        end else begin
          holder = -1;
          beats  = 0;
        end
        last = win;
      end else begin
        holder = -1;
        beats  = 0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    preload(20'h00010, 24'h5A0010);
    preload(20'h00020, 24'hA50020);
    test_reset();
    test_write_read();
    test_read_first();
    test_reset_mid_read();
    test_lock_limit();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, default 24: bits per memory word.
REQ-002 Parameter RAM_ADDR_BITS, default 20: address width (1,048,576 words; a 1024x768 frame needs 786,432).
REQ-003 Parameter MAX_BURST, default 16: maximum consecutive grants to one requester while it holds lock.
REQ-004 Port clock  input  1  single clock; all logic is rising-edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Ports a_valid / b_valid  input  1  requester A/B presents a request.
REQ-007 Ports a_write / b_write  input  1  1 = write, 0 = read.
REQ-008 Ports a_lock / b_lock  input  1  requests that the grant be held for the next beat.
REQ-009 Ports a_addr / b_addr  input  RAM_ADDR_BITS  word address.
REQ-010 Ports a_wdata / b_wdata  input  RAM_WIDTH  write data.
REQ-011 Ports a_ready / b_ready  output  1  request accepted this cycle.
REQ-012 Ports a_rvalid / b_rvalid  output  1  read data valid.
REQ-013 Port rdata  output  RAM_WIDTH  read data, shared by both requesters and qualified by a_rvalid/b_rvalid.

Function
REQ-014 A request transfers when valid and ready are both high on a rising edge; at most one ready is high per cycle.
REQ-015 ready is combinational from the valids and arbiter state; it has no dependency on rdata.
REQ-016 Arbitration is round-robin: with both valids high and no lock in force, the grant goes to the requester not granted last.
REQ-017 A single active valid is granted immediately, regardless of round-robin state.
REQ-018 Lock: if the granted requester transfers with lock=1, it keeps priority on the next cycle.
REQ-019 A burst is one or more consecutive locked beats; beat_cnt counts the beats in the current burst.
REQ-020 When beat_cnt reaches MAX_BURST, priority passes to the other requester if it is valid, even if lock is still asserted, and beat_cnt clears.
REQ-021 beat_cnt clears on any unlocked transfer or any cycle without a transfer.
REQ-022 The block has 3 states: IDLE, OWN_A, OWN_B.
REQ-023 State transitions: IDLE -> OWN_x on a locked grant to x. OWN_x -> IDLE when x transfers unlocked, drops valid, or hits MAX_BURST with the other side idle. OWN_x -> OWN_y on forced handover when y is locked.
REQ-024 The memory sees ram_enable = (transfer occurred), with write_enable, address and input_data muxed from the granted requester in the same cycle.
REQ-025 Read latency is exactly 1 cycle: rvalid of the requester that issued the read rises the cycle after acceptance, with rdata = the memory word.
REQ-026 Writes produce no rvalid.
REQ-027 Read-during-write to the same address returns the old data (read-first memory).
REQ-028 Back-to-back reads sustain one per cycle; rvalid toggles owner to match the accepting requester.
REQ-029 A write from A followed by a read from B of the same address in the next cycle returns the new data.
REQ-030 Address wrap is none: addresses are used as-is; out-of-frame addresses are not checked.

Reset
REQ-031 While reset_n is low: a_ready, b_ready, a_rvalid and b_rvalid are 0; rdata is 0; state is IDLE; beat_cnt is 0; last_grant = B, so A wins the first contention.
REQ-032 Reset asserted with a read in flight discards its rvalid; memory contents are not cleared.
REQ-033 After deassertion, the first grant may occur on the first rising edge.

Structure
REQ-034 RAM_WIDTH and RAM_ADDR_BITS defaults and state encodings reside in the shared package bram_pkg.
REQ-035 The memory is the existing block RAM module, instantiated as the sole sub-module (instance u_bram), with its width and address parameters passed through.
REQ-036 Arbitration, state machine and response tracking are in this module.

Verification
REQ-037 Reset-then-contend: reset_n low 3 cycles, release, both valid unlocked reads to 0x00010/0x00020 -> A granted cycle 1, B cycle 2; a_rvalid cycle 2, b_rvalid cycle 3 with stored words.
REQ-038 Write/read: A writes 0xABCDEF to 0x0BFFFF, next cycle B reads 0x0BFFFF -> b_rvalid the following cycle with rdata = 0xABCDEF.
REQ-039 Lock limit: MAX_BURST=4, A locked valid continuously, B valid -> A granted 4 beats, B 1 beat, A resumes.
REQ-040 Read-first: same cycle write 0x123456 to 0x00005 (previously 0x000001) -> rvalid not asserted; a subsequent read returns 0x123456, and a read issued in the write's own beat by design order returns 0x000001.
REQ-041 Reset mid-read: read accepted, reset_n low before the next edge -> no rvalid; state IDLE; memory word preserved on later read.
REQ-042 Idle: both valids low 10 cycles -> ram_enable 0 and no ready or rvalid asserted.
